// File: rtl/tfc_pkg.sv
// Shared light codes, monitor states and fault bit positions
// for the traffic-light conflict monitor.
package tfc_pkg;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    localparam int F_CONFLICT = 0;
    localparam int F_ILLEGAL  = 1;
    localparam int F_BAD_SEQ  = 2;
    localparam int F_MIN_TIME = 3;

    typedef enum logic [1:0] {
        ST_MONITOR  = 2'b00,
        ST_FAULT    = 2'b01,
        ST_CLEARING = 2'b10
    } mon_state_e;

endpackage

// File: rtl/tfc_light_tracker.sv
// Per-light tracker: previous code, dwell counter and
// sequence / minimum-time / illegal-code checks.
import tfc_pkg::*;

module tfc_light_tracker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned GRN_MIN = 4,
    parameter int unsigned YEL_MIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] code,
    output logic       ill,
    output logic       bad_seq,
    output logic       min_time
);

    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;

    // An illegal code freezes the history; a change checks the
    // transition and restarts the dwell, a hold extends it.
    always_comb begin
        prev_d   = prev_q;
        dwell_d  = dwell_q;
        ill      = 1'b0;
        bad_seq  = 1'b0;
        min_time = 1'b0;
        if (code == BAD) begin
            ill = 1'b1;
        end else if (code != prev_q) begin
            bad_seq = (prev_q == GRN && code == RED) ||
                      (prev_q == YEL && code == GRN) ||
                      (prev_q == RED && code == YEL);
            min_time =
                (prev_q == GRN &&
                 dwell_q < CNT_W'(GRN_MIN)) ||
                (prev_q == YEL &&
                 dwell_q < CNT_W'(YEL_MIN));
            prev_d  = code;
            dwell_d = CNT_W'(1);
        end else if (dwell_q != '1) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // History registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= RED;
            dwell_q <= '0;
        end else begin
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/tfc_signal_monitor.sv
// Conflict monitor: conflict logic, fault FSM, all-red
// recovery counter and flash divider.
import tfc_pkg::*;

module tfc_signal_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GRN_MIN    = 4,
    parameter int unsigned YEL_MIN    = 2,
    parameter int unsigned ALLRED_MIN = 3,
    parameter int unsigned FLASH_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] main_l,
    input  logic [1:0] side_l,
    input  logic       ped_l,
    input  logic       clr_fault,
    output logic       fault,
    output logic [3:0] fault_code,
    output logic       flash,
    output logic [1:0] mon_state
);

    logic m_ill, m_seq, m_min;
    logic s_ill, s_seq, s_min;

    tfc_light_tracker #(
        .CNT_W(CNT_W), .GRN_MIN(GRN_MIN),
        .YEL_MIN(YEL_MIN)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .code(main_l),
        .ill(m_ill), .bad_seq(m_seq), .min_time(m_min)
    );

    tfc_light_tracker #(
        .CNT_W(CNT_W), .GRN_MIN(GRN_MIN),
        .YEL_MIN(YEL_MIN)
    ) u_side (
        .clk(clk), .rst_n(rst_n), .code(side_l),
        .ill(s_ill), .bad_seq(s_seq), .min_time(s_min)
    );

    mon_state_e       state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [CNT_W-1:0] allred_q, allred_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             flash_q, flash_d;
    logic [3:0]       viol;
    logic             main_go, side_go, all_red;

    // Decode this edge's violations into fault bit positions
    always_comb begin
        main_go = (main_l != RED);
        side_go = (side_l != RED);
        all_red = !main_go && !side_go && !ped_l;
        viol = '0;
        viol[F_CONFLICT] = (main_go && side_go) ||
                           (ped_l && (main_go || side_go));
        viol[F_ILLEGAL]  = m_ill | s_ill;
        viol[F_BAD_SEQ]  = m_seq | s_seq;
        viol[F_MIN_TIME] = m_min | s_min;
    end

    // Fault FSM, sticky code, all-red counter and flash divider
    always_comb begin
        state_d  = state_q;
        code_d   = code_q | viol;
        allred_d = '0;
        div_d    = '0;
        flash_d  = 1'b0;
        unique case (state_q)
            ST_MONITOR: begin
                if (viol != '0) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (viol == '0 && clr_fault)
                    state_d = ST_CLEARING;
            end
            ST_CLEARING: begin
                if (viol != '0) begin
                    state_d = ST_FAULT;
                end else begin
                    if (all_red && allred_q != '1)
                        allred_d = allred_q + 1'b1;
                    else if (all_red)
                        allred_d = allred_q;
                    if (allred_d == CNT_W'(ALLRED_MIN)) begin
                        state_d  = ST_MONITOR;
                        code_d   = '0;
                        allred_d = '0;
                    end
                end
            end
            default: state_d = ST_MONITOR;
        endcase
        if (state_q == ST_FAULT && state_d == ST_FAULT) begin
            flash_d = flash_q;
            div_d   = div_q + 1'b1;
            if (div_q == CNT_W'(FLASH_DIV - 1)) begin
                div_d   = '0;
                flash_d = ~flash_q;
            end
        end
    end

    // Monitor state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_MONITOR;
            code_q   <= '0;
            allred_q <= '0;
            div_q    <= '0;
            flash_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            allred_q <= allred_d;
            div_q    <= div_d;
            flash_q  <= flash_d;
        end
    end

    assign fault      = (state_q != ST_MONITOR);
    assign fault_code = code_q;
    assign flash      = flash_q;
    assign mon_state  = state_q;

endmodule
